// File: rtl/arm_pkg.sv
// Shared ARM decode constants: instruction modes, data-processing opcodes,
// condition codes, execute-command encodings and the condition evaluator.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // status is {N,Z,C,V}; the 1111 condition never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = status;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with synchronous write, asynchronous read
// and optional same-cycle write-to-read forwarding.
module register_file #(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 16,
  parameter int RF_BYPASS = 1,
  localparam int REG_AW   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    if (RF_BYPASS != 0 && wr_en) begin
      if (wr_addr == rd_addr1) rd_data1 = wr_data;
      if (wr_addr == rd_addr2) rd_data2 = wr_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// ARM decode stage: field split, condition check, control decode, operand
// read and the ID/EX pipeline register with bubble/flush/hold handling.
module id_stage
  import arm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 16,
  parameter int RF_BYPASS = 1,
  localparam int REG_AW   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        status,
  input  logic              stall,
  input  logic              flush,
  input  logic              freeze,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [REG_AW-1:0] hz_src1,
  output logic [REG_AW-1:0] hz_src2,
  output logic              hz_two_src,
  output logic [3:0]        ex_cmd,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_enable,
  output logic              branch,
  output logic              s_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [REG_AW-1:0] dest,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] pc_out
);

  logic [3:0]        cond;
  logic [1:0]        mode;
  logic              imm;
  logic [3:0]        opcode;
  logic              s_bit;
  logic [REG_AW-1:0] rn, rd, rm;
  logic              is_store;
  logic              bubble;

  logic [3:0] dec_cmd;
  logic       dec_mem_read, dec_mem_write, dec_wb, dec_branch, dec_s;

  logic [DATA_W-1:0] rd_data1, rd_data2;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign imm    = instruction[25];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign rn     = instruction[16 +: REG_AW];
  assign rd     = instruction[12 +: REG_AW];
  assign rm     = instruction[0 +: REG_AW];

  assign is_store   = (mode == MODE_MEM) && !s_bit;
  assign hz_src1    = rn;
  assign hz_src2    = is_store ? rd : rm;
  assign hz_two_src = (!imm || is_store) && (mode != MODE_BR);

  always_comb begin
    dec_cmd       = EXE_NOP;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wb        = 1'b0;
    dec_branch    = 1'b0;
    dec_s         = 1'b0;
    case (mode)
      MODE_DP: begin
        dec_s  = s_bit;
        dec_wb = 1'b1;
        case (opcode)
          OP_MOV: dec_cmd = EXE_MOV;
          OP_MVN: dec_cmd = EXE_MVN;
          OP_ADD: dec_cmd = EXE_ADD;
          OP_ADC: dec_cmd = EXE_ADC;
          OP_SUB: dec_cmd = EXE_SUB;
          OP_SBC: dec_cmd = EXE_SBC;
          OP_AND: dec_cmd = EXE_AND;
          OP_ORR: dec_cmd = EXE_ORR;
          OP_EOR: dec_cmd = EXE_EOR;
          OP_CMP: begin dec_cmd = EXE_SUB; dec_wb = 1'b0; end
          OP_TST: begin dec_cmd = EXE_AND; dec_wb = 1'b0; end
          default: begin dec_s = 1'b0; dec_wb = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        // S doubles as the load flag; address is always computed with ADD
        dec_cmd       = EXE_ADD;
        dec_mem_read  = s_bit;
        dec_wb        = s_bit;
        dec_mem_write = !s_bit;
      end
      MODE_BR: dec_branch = 1'b1;
      default: ;
    endcase
  end

  assign bubble = !cond_pass(cond, status) || stall || flush;

  register_file #(
    .DATA_W   (DATA_W),
    .REG_N    (REG_N),
    .RF_BYPASS(RF_BYPASS)
  ) u_register_file (
    .clk     (clk),
    .rst     (rst),
    .rd_addr1(rn),
    .rd_addr2(hz_src2),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2),
    .wr_en   (wb_en),
    .wr_addr (wb_dest),
    .wr_data (wb_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_cmd        <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      wb_enable     <= 1'b0;
      branch        <= 1'b0;
      s_out         <= 1'b0;
      imm_out       <= 1'b0;
      shift_operand <= '0;
      signed_imm24  <= '0;
      dest          <= '0;
      src1          <= '0;
      src2          <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      pc_out        <= '0;
    end else if (!freeze) begin
      ex_cmd        <= bubble ? EXE_NOP : dec_cmd;
      mem_read      <= !bubble && dec_mem_read;
      mem_write     <= !bubble && dec_mem_write;
      wb_enable     <= !bubble && dec_wb;
      branch        <= !bubble && dec_branch;
      s_out         <= !bubble && dec_s;
      imm_out       <= imm;
      shift_operand <= instruction[11:0];
      signed_imm24  <= instruction[23:0];
      dest          <= rd;
      src1          <= rn;
      src2          <= hz_src2;
      val_rn        <= rd_data1;
      val_rm        <= rd_data2;
      pc_out        <= pc_in;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Full ARM instruction-decode pipeline stage.
- Splits the 32-bit instruction into its fields and evaluates the condition field against the NZCV status bits.
- Generates the execute command and the memory, writeback and branch control signals.
- Reads two operands from an internal register file that has a writeback port, and registers everything into the ID/EX pipeline register.
- Supports stall (bubble), flush and freeze (hold), so it can sit between the fetch stage and the execute stage with a hazard unit alongside.

Parameters:
- DATA_W, 32, width of register-file data, PC and operand values.
- REG_N, 16, number of architectural registers; REG_N is a power of two, so REG_AW = log2(REG_N).
- RF_BYPASS, 1, when 1 a same-cycle writeback to a register being read is forwarded to the read data.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instruction  in  32  instruction from the IF/ID register
- pc_in  in  DATA_W  PC+4 paired with the instruction
- status  in  4  {N,Z,C,V} from the status register
- stall  in  1  hazard detected; insert a bubble into ID/EX
- flush  in  1  branch taken in EX; insert a bubble into ID/EX
- freeze  in  1  downstream wait; hold ID/EX unchanged
- wb_en  in  1  register-file write enable
- wb_dest  in  REG_AW  write address
- wb_value  in  DATA_W  write data
- hz_src1  out  REG_AW  combinational Rn, for the hazard unit
- hz_src2  out  REG_AW  combinational second source: Rd for STR, Rm otherwise
- hz_two_src  out  1  combinational; 1 when the instruction reads a second register (imm=0 or STR) and is not a branch
- ex_cmd  out  4  registered execute command
- mem_read, mem_write, wb_enable, branch, s_out, imm_out  out  1 each  registered control signals
- shift_operand  out  12  registered instr[11:0]
- signed_imm24  out  24  registered instr[23:0]
- dest  out  REG_AW  registered Rd
- src1, src2  out  REG_AW  registered sources, for forwarding
- val_rn, val_rm  out  DATA_W  registered operand values
- pc_out  out  DATA_W  registered PC

Behaviour:
- Fields: cond = [31:28], mode = [27:26], imm = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12], Rm = [3:0]. When REG_N is below 16, the upper bits of each register field are ignored.
- Condition pass: cond is tested against status as follows.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL (1110) passes; 1111 fails.
- Decode for mode 00 (opcode → ex_cmd, wb_enable):
  - MOV 1101 → 0001, wb=1; MVN 1111 → 1001, wb=1
  - ADD 0100 → 0010, wb=1; ADC 0101 → 0011, wb=1
  - SUB 0010 → 0100, wb=1; SBC 0110 → 0101, wb=1
  - AND 0000 → 0110, wb=1; ORR 1100 → 0111, wb=1; EOR 0001 → 1000, wb=1
  - CMP 1010 → 0100, wb=0; TST 1000 → 0110, wb=0
  - Any other opcode: all controls 0.
- Mode 01 (LDR/STR): ex_cmd = 0010, S is the load flag.
  - S=1 (LDR): mem_read=1, wb=1.
  - S=0 (STR): mem_write=1.
  - s_out = 0 for both.
- Mode 10: branch=1, all other controls 0. Mode 11: all controls 0.
- Bubble: when condition pass = 0, or stall = 1, or flush = 1, the controls latched into ID/EX are forced to 0: ex_cmd, mem_read, mem_write, wb_enable, branch and s_out. Data fields are latched as normal.
- ID/EX update priority, evaluated each rising edge:
  - rst: all outputs and all register-file entries go to 0.
  - else freeze: ID/EX holds its contents; the register-file write still occurs.
  - else flush or stall: bubble.
  - else: normal latch.
  - Decode-to-output latency is 1 cycle.
- Register file:
  - Synchronous write on the rising edge when wb_en = 1; asynchronous read.
  - RF_BYPASS = 1: if wb_en = 1 and wb_dest equals a read address, that read returns wb_value in the same cycle.
  - RF_BYPASS = 0: the read returns the old value.
- hz_* outputs are combinational and ignore stall, flush and freeze.
- Reset asserted while freeze = 1: reset wins.

Decomposition:
- Package arm_pkg holds: the mode, opcode and cond localparams; the EXE_CMD encodings; and a helper function cond_pass(cond, status).
- Sub-module register_file (parameters DATA_W, REG_N, RF_BYPASS) with two read ports and one write port.
- The remaining decode and pipeline-register logic stays in id_stage.

Test Plan:
- ADD, cond=AL: wb_dest=1, value 5 and wb_dest=2, value 7 written earlier; instruction 0xE0813002 (ADD R3,R1,R2) → next cycle ex_cmd=0010, wb_enable=1, dest=3, val_rn=5, val_rm=7, hz_two_src was 1.
- Condition fail: status=0100 (Z=1), instruction NE-MOV 0x13A0000A → ex_cmd=0, wb_enable=0, shift_operand=0x00A.
- LDR vs STR:
  - 0xE5910004 → mem_read=1, wb_enable=1, ex_cmd=0010.
  - 0xE5810004 → mem_write=1, hz_src2=Rd=0, hz_two_src=1.
- Freeze then flush:
  - Latch an ADD, then hold freeze=1 for 3 cycles with new instructions presented → outputs unchanged.
  - Release freeze with flush=1 → all controls 0.
- Bypass: wb_en=1, wb_dest=1, wb_value=0x55 in the same cycle as a read of R1 → val_rn=0x55 (RF_BYPASS=1); old value with RF_BYPASS=0.
- Reset mid-stream: assert rst during a branch (0xEAFFFFFE) → next edge all outputs 0, and a subsequent read of R1 returns 0.
